// File: rtl/frame_write_scheduler_pkg.sv
// Shared frame-buffer constants and scheduler state encoding, also used by
// the frame buffer RAMs and the sprite clients.
package frame_pkg;
    localparam int H_RES  = 640;
    localparam int V_RES  = 480;
    localparam int ADDR_W = 19;
    localparam int PIX_W  = 5;
    localparam logic [PIX_W-1:0] TRANSPARENT = 5'h15;

    typedef enum logic [1:0] {
        DRAW,
        READY,
        SWAP,
        START
    } sched_state_t;
endpackage

// File: rtl/frame_write_scheduler_if.sv
// Client request/grant bus, back-buffer write port and frame control signals.
// req is held with stable data until grant is high on a rising edge; the pixel is consumed on that edge.
interface frame_write_scheduler_if #(
    parameter int N = 4
);
    import frame_pkg::*;
    localparam int RR_W = (N > 1) ? $clog2(N) : 1;

    logic                        VS;
    logic [N-1:0]                req;
    logic [N-1:0][9:0]           req_x;
    logic [N-1:0][9:0]           req_y;
    logic [N-1:0][PIX_W-1:0]     req_pixel;
    logic [N-1:0]                done;
    logic [N-1:0]                grant;
    logic                        wr_en;
    logic [ADDR_W-1:0]           wr_addr;
    logic [PIX_W-1:0]            wr_pixel;
    logic                        back_sel;
    logic                        frame_start;
    logic [7:0]                  drop_count;
    sched_state_t                state;
    logic [RR_W-1:0]             rr;

    modport master (
        output VS, req, req_x, req_y, req_pixel, done,
        input  grant, wr_en, wr_addr, wr_pixel, back_sel, frame_start,
               drop_count, state, rr
    );

    modport slave (
        input  VS, req, req_x, req_y, req_pixel, done,
        output grant, wr_en, wr_addr, wr_pixel, back_sel, frame_start,
               drop_count, state, rr
    );
endinterface

// File: rtl/frame_write_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: grants the first requester at or after rr, modulo N.
module rr_arbiter #(
    parameter int N = 4
) (
    input  logic [N-1:0]                        req,
    input  logic [((N > 1) ? $clog2(N) : 1)-1:0] rr,
    output logic [N-1:0]                        grant
);
    localparam int RR_W = (N > 1) ? $clog2(N) : 1;

    logic            found;
    logic [RR_W-1:0] idx;

    always_comb begin
        grant = '0;
        found = 1'b0;
        idx   = '0;
        for (int i = 0; i < N; i++) begin
            idx = RR_W'((int'(rr) + i) % N);
            if (!found && req[idx]) begin
                grant[idx] = 1'b1;
                found      = 1'b1;
            end
        end
    end
endmodule

// File: rtl/frame_write_scheduler.sv
// Arbitrates sprite-engine pixel writes into the back buffer, filters invisible
// pixels, and swaps front/back buffers on vertical sync once every client is done.
module frame_write_scheduler
    import frame_pkg::*;
#(
    parameter int                N           = 4,
    parameter logic [PIX_W-1:0]  TRANSPARENT = frame_pkg::TRANSPARENT,
    parameter int                H_RES       = frame_pkg::H_RES,
    parameter int                V_RES       = frame_pkg::V_RES
) (
    input  logic                 Clk,
    input  logic                 Reset,
    frame_write_scheduler_if.slave bus
);
    localparam int RR_W         = (N > 1) ? $clog2(N) : 1;
    localparam bit SHIFT_STRIDE = (H_RES == 640);

    sched_state_t      state, state_next;
    logic [RR_W-1:0]   rr, rr_next;
    logic              vs_q, vs_fall;
    logic [N-1:0]      arb_req, grant;
    logic [9:0]        sel_x, sel_y;
    logic [PIX_W-1:0]  sel_pix;
    logic [ADDR_W-1:0] addr;
    logic              visible, write_ok;
    logic              wr_en_q, back_sel_q, frame_start_q;
    logic [ADDR_W-1:0] wr_addr_q;
    logic [PIX_W-1:0]  wr_pixel_q;
    logic [7:0]        drop_q;

    assign vs_fall = vs_q & ~bus.VS;
    assign arb_req = (state == DRAW) ? bus.req : '0;

    rr_arbiter #(.N(N)) u_arb (
        .req   (arb_req),
        .rr    (rr),
        .grant (grant)
    );

    always_comb begin
        sel_x   = '0;
        sel_y   = '0;
        sel_pix = '0;
        rr_next = rr;
        for (int i = 0; i < N; i++) begin
            if (grant[i]) begin
                sel_x   = bus.req_x[i];
                sel_y   = bus.req_y[i];
                sel_pix = bus.req_pixel[i];
                rr_next = RR_W'((i + 1) % N);
            end
        end
    end

    // 640 = 512 + 128, so the default stride needs only two shifts and adds.
    always_comb begin
        if (SHIFT_STRIDE)
            addr = ADDR_W'(sel_x) + (ADDR_W'(sel_y) << 9) + (ADDR_W'(sel_y) << 7);
        else
            addr = ADDR_W'(sel_x) + ADDR_W'(sel_y) * ADDR_W'(H_RES);
    end

    assign visible  = (32'(sel_x) < 32'(H_RES)) && (32'(sel_y) < 32'(V_RES));
    assign write_ok = (|grant) && visible && (sel_pix != TRANSPARENT);

    // done is ignored during the frame_start cycle so clients have that cycle to drop it.
    always_comb begin
        state_next = state;
        case (state)
            DRAW:    if ((&bus.done) && !frame_start_q) state_next = READY;
            READY:   if (vs_fall) state_next = SWAP;
            SWAP:    state_next = START;
            START:   state_next = DRAW;
            default: state_next = DRAW;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state         <= DRAW;
            rr            <= '0;
            vs_q          <= 1'b1;
            back_sel_q    <= 1'b1;
            frame_start_q <= 1'b0;
            drop_q        <= '0;
            wr_en_q       <= 1'b0;
            wr_addr_q     <= '0;
            wr_pixel_q    <= '0;
        end else begin
            state         <= state_next;
            rr            <= rr_next;
            vs_q          <= bus.VS;
            back_sel_q    <= back_sel_q ^ (state == SWAP);
            frame_start_q <= (state == START);
            wr_en_q       <= write_ok;
            if (write_ok) begin
                wr_addr_q  <= addr;
                wr_pixel_q <= sel_pix;
            end
            if ((state == DRAW) && vs_fall && (drop_q != 8'hFF))
                drop_q <= drop_q + 8'd1;
        end
    end

    assign bus.grant       = grant;
    assign bus.wr_en       = wr_en_q;
    assign bus.wr_addr     = wr_addr_q;
    assign bus.wr_pixel    = wr_pixel_q;
    assign bus.back_sel    = back_sel_q;
    assign bus.frame_start = frame_start_q;
    assign bus.drop_count  = drop_q;
    assign bus.state       = state;
    assign bus.rr          = rr;
endmodule

// File: tb/tb_frame_write_scheduler.sv
// Bench for frame_write_scheduler: directed stimulus with queued expected grants
// and writes, checked by a negedge monitor, plus direct checks of frame control.
module tb_frame_write_scheduler;
    import frame_pkg::*;

    logic Clk = 1'b0;
    logic Reset = 1'b1;
    always #5 Clk = ~Clk;

    frame_write_scheduler_if #(.N(4)) bus ();

    frame_write_scheduler #(.N(4)) dut (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;
    logic grant_mon_en = 1'b1;

    logic [3:0]  exp_grant_q[$];
    logic [23:0] exp_wr_q[$];

    // Hand-computed x + y*640 for the fairness vectors (x = 100*i+5, y = i+1).
    logic [18:0] addr_tbl [4] = '{19'd645, 19'd1385, 19'd2125, 19'd2865};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic load_fair_pixels();
        for (int i = 0; i < 4; i++) begin
            bus.req_x[i]     = 10'(100 * i + 5);
            bus.req_y[i]     = 10'(i + 1);
            bus.req_pixel[i] = 5'(i + 1);
        end
    endtask

    task automatic push_fair(input int k);
        exp_grant_q.push_back(4'b0001 << k);
        exp_wr_q.push_back({addr_tbl[k], 5'(k + 1)});
    endtask

    always @(negedge Clk) begin
        if (!Reset && grant_mon_en && (bus.grant != 4'b0)) begin
            if (exp_grant_q.size() == 0) begin
                check("unexpected_grant", 32'(bus.grant), 32'h0);
            end else begin
                check("grant", 32'(bus.grant), 32'(exp_grant_q.pop_front()));
            end
        end
        if (bus.wr_en) begin
            if (exp_wr_q.size() == 0) begin
                check("unexpected_write", {8'h0, bus.wr_addr, bus.wr_pixel}, 32'h0);
            end else begin
                check("write", {8'h0, bus.wr_addr, bus.wr_pixel}, {8'h0, exp_wr_q.pop_front()});
            end
        end
    end

    initial begin
        bus.VS = 1'b1;
        bus.req = '0;
        bus.done = '0;
        bus.req_x = '0;
        bus.req_y = '0;
        bus.req_pixel = '0;

        // Reset state
        repeat (3) tick();
        check("rst_back_sel", 32'(bus.back_sel), 32'd1);
        check("rst_wr_en", 32'(bus.wr_en), 32'd0);
        check("rst_drop", 32'(bus.drop_count), 32'd0);
        check("rst_grant", 32'(bus.grant), 32'd0);
        check("rst_state", 32'(bus.state), 32'(DRAW));
        check("rst_rr", 32'(bus.rr), 32'd0);
        check("rst_frame_start", 32'(bus.frame_start), 32'd0);
        Reset = 1'b0;
        tick();

        // Round-robin with all four clients requesting, then with 1010
        load_fair_pixels();
        for (int c = 0; c < 8; c++) push_fair(c % 4);
        bus.req = 4'b1111;
        repeat (8) tick();
        for (int c = 0; c < 4; c++) push_fair((c % 2 == 0) ? 1 : 3);
        bus.req = 4'b1010;
        repeat (4) tick();
        bus.req = '0;
        tick();

        // Write path: largest legal address, then filtered pixels
        bus.req_x[2] = 10'd639;
        bus.req_y[2] = 10'd479;
        bus.req_pixel[2] = 5'h07;
        exp_grant_q.push_back(4'b0100);
        exp_wr_q.push_back({19'd307199, 5'h07});
        bus.req = 4'b0100;
        tick();
        bus.req_x[2] = 10'd10;
        bus.req_y[2] = 10'd10;
        bus.req_pixel[2] = 5'h15;
        exp_grant_q.push_back(4'b0100);
        tick();
        check("transparent_wr_en", 32'(bus.wr_en), 32'd0);
        bus.req_x[2] = 10'd640;
        bus.req_y[2] = 10'd0;
        bus.req_pixel[2] = 5'h07;
        exp_grant_q.push_back(4'b0100);
        tick();
        check("x_offscreen_wr_en", 32'(bus.wr_en), 32'd0);
        bus.req_x[2] = 10'd0;
        bus.req_y[2] = 10'd480;
        exp_grant_q.push_back(4'b0100);
        tick();
        check("y_offscreen_wr_en", 32'(bus.wr_en), 32'd0);
        bus.req = '0;
        tick();

        // Normal swap with requests held high (rr is 3 here)
        load_fair_pixels();
        bus.done = 4'b1111;
        tick();
        check("swap_ready_state", 32'(bus.state), 32'(READY));
        grant_mon_en = 1'b0;
        bus.req = 4'b1111;
        bus.VS = 1'b0;
        #1;
        check("swap_ready_grant", 32'(bus.grant), 32'd0);
        check("swap_ready_back_sel", 32'(bus.back_sel), 32'd1);
        tick();
        check("swap_state", 32'(bus.state), 32'(SWAP));
        check("swap_grant", 32'(bus.grant), 32'd0);
        check("swap_back_sel_hold", 32'(bus.back_sel), 32'd1);
        check("swap_fs_low", 32'(bus.frame_start), 32'd0);
        tick();
        check("start_state", 32'(bus.state), 32'(START));
        check("start_grant", 32'(bus.grant), 32'd0);
        check("start_back_sel", 32'(bus.back_sel), 32'd0);
        check("start_fs_low", 32'(bus.frame_start), 32'd0);
        bus.VS = 1'b1;
        tick();
        check("fs_high", 32'(bus.frame_start), 32'd1);
        check("fs_state", 32'(bus.state), 32'(DRAW));
        check("fs_grant", 32'(bus.grant), 32'b1000);
        exp_wr_q.push_back({addr_tbl[3], 5'd4});
        bus.done = '0;
        tick();
        check("fs_pulse_end", 32'(bus.frame_start), 32'd0);
        check("fs_back_sel", 32'(bus.back_sel), 32'd0);
        bus.req = '0;
        grant_mon_en = 1'b1;
        tick();

        // Dropped frame, then a real swap on the next VS
        bus.done = 4'b0111;
        bus.VS = 1'b0;
        tick();
        check("drop_count_1", 32'(bus.drop_count), 32'd1);
        check("drop_state", 32'(bus.state), 32'(DRAW));
        bus.VS = 1'b1;
        tick();
        check("drop_back_sel", 32'(bus.back_sel), 32'd0);
        bus.done = 4'b1111;
        tick();
        bus.VS = 1'b0;
        tick();
        bus.VS = 1'b1;
        tick();
        check("after_drop_swap", 32'(bus.back_sel), 32'd1);
        bus.done = '0;
        tick();
        check("after_drop_fs", 32'(bus.frame_start), 32'd1);
        check("after_drop_count", 32'(bus.drop_count), 32'd1);
        tick();

        // Saturation of drop_count
        for (int n = 0; n < 300; n++) begin
            bus.VS = 1'b0;
            tick();
            bus.VS = 1'b1;
            tick();
        end
        check("drop_saturate", 32'(bus.drop_count), 32'd255);

        // Reset mid-frame after a swap and a grant
        bus.done = 4'b1111;
        tick();
        bus.VS = 1'b0;
        tick();
        bus.VS = 1'b1;
        tick();
        tick();
        bus.done = '0;
        tick();
        check("pre_reset_back_sel", 32'(bus.back_sel), 32'd0);
        push_fair(0);
        bus.req = 4'b0001;
        tick();
        check("pre_reset_rr", 32'(bus.rr), 32'd1);
        bus.req = 4'b0100;
        Reset = 1'b1;
        tick();
        check("mid_reset_wr_en", 32'(bus.wr_en), 32'd0);
        check("mid_reset_rr", 32'(bus.rr), 32'd0);
        check("mid_reset_back_sel", 32'(bus.back_sel), 32'd1);
        check("mid_reset_drop", 32'(bus.drop_count), 32'd0);
        check("mid_reset_state", 32'(bus.state), 32'(DRAW));
        bus.req = '0;
        Reset = 1'b0;
        repeat (2) tick();

        check("grant_queue_empty", 32'(exp_grant_q.size()), 32'd0);
        check("write_queue_empty", 32'(exp_wr_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
